rainbow_phase_decoder: RTL

//  Receive-side peer of the rainbow light rotator. Samples its six phase lines (three adjacent lit,

---
 rtl/rainbow_pkg.sv | 37 +++
 rtl/rainbow_phase_decoder_if.sv | 34 +++
 rtl/rainbow_phase_decoder_sync_2ff.sv | 29 ++
 rtl/rainbow_phase_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rainbow_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rainbow_pkg
//  Purpose  : Shared types, constants and pattern decode for the rainbow
//             phase decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package rainbow_pkg;

    localparam int NUM_PHASES = 6;

    typedef logic [2:0] phase_idx_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // Returns {valid, idx}. Three adjacent lit lines form a legal phase;
    // every other pattern decodes as invalid with idx 0.
    function automatic logic [3:0] pattern_to_idx(input logic [5:0] pat);
        logic [3:0] res;
        case (pat)
            6'b000111: res = {1'b1, 3'd0};
            6'b001110: res = {1'b1, 3'd1};
            6'b011100: res = {1'b1, 3'd2};
            6'b111000: res = {1'b1, 3'd3};
            6'b110001: res = {1'b1, 3'd4};
            6'b100011: res = {1'b1, 3'd5};
            default:   res = 4'b0000;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rainbow_phase_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : rainbow_phase_decoder_if
//  Purpose  : Phase lines, error clear and status outputs of the decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface rainbow_phase_decoder_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       phase_in;
    logic             clear_err;
    logic [2:0]       phase_idx;
    logic             phase_valid;
    logic             step;
    logic             dir;
    logic             locked;
    logic [CNT_W-1:0] interval;
    logic             err_pattern;
    logic             err_skip;
    logic             err_timeout;

    modport master (
        output phase_in, clear_err,
        input  phase_idx, phase_valid, step, dir, locked, interval,
               err_pattern, err_skip, err_timeout
    );

    modport slave (
        input  phase_in, clear_err,
        output phase_idx, phase_valid, step, dir, locked, interval,
               err_pattern, err_skip, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/rainbow_phase_decoder_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchroniser for asynchronous inputs, active-low
//             synchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire              clk,
    input  wire              reset,
    input  wire  [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= '0;
            q      <= '0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end
endmodule
`default_nettype wire

// File: rtl/rainbow_phase_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : rainbow_phase_decoder
//  Purpose  : Decodes the rotating six-line rainbow phase pattern into an
//             index and direction, measures step interval, tracks lock and
//             reports illegal patterns, skipped steps and stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module rainbow_phase_decoder
    import rainbow_pkg::*;
#(
    parameter int LIGHT_INTERVAL = 12_000_000,
    parameter int TIMEOUT_CYCLES = 2 * LIGHT_INTERVAL,
    parameter int LOCK_STEPS     = 3,
    parameter int CNT_W          = 32
) (
    input wire                      clk,
    input wire                      reset,
    rainbow_phase_decoder_if.slave  bus
);
    localparam int GOOD_W = $clog2(LOCK_STEPS + 1);

    localparam logic [1:0]       c_st_unlocked  = UNLOCKED;
    localparam logic [1:0]       c_st_acquire   = ACQUIRE;
    localparam logic [1:0]       c_st_locked    = LOCKED;
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GOOD_W-1:0] c_lock_steps  = GOOD_W'(LOCK_STEPS);

    logic [5:0]        w_synced;
    logic [5:0]        r_prev;
    phase_idx_t        r_phase_idx;
    logic              r_phase_valid;
    logic              r_step;
    logic              r_dir;
    logic [1:0]        r_state;
    logic [GOOD_W-1:0] r_good;
    logic [CNT_W-1:0]  r_gap;
    logic [CNT_W-1:0]  r_interval;
    logic              r_err_pattern;
    logic              r_err_skip;
    logic              r_err_timeout;

    logic [3:0]        w_dec;
    logic              w_new_valid;
    phase_idx_t        w_new_idx;
    phase_idx_t        w_p_next;
    phase_idx_t        w_p_prev;
    logic              w_change;
    logic              w_fwd;
    logic              w_bwd;
    logic              w_legal_chg;
    logic              w_illegal_chg;
    logic              w_is_step;
    logic              w_is_skip;
    logic              w_err_pat_set;
    logic              w_timeout;
    logic [1:0]        w_state_next;
    logic [GOOD_W-1:0] w_good_next;

    sync_2ff #(.WIDTH(6)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.phase_in),
        .q     (w_synced)
    );

    // Classify the synced pattern against the previous one.
    always_comb begin
        w_dec         = pattern_to_idx(w_synced);
        w_new_valid   = w_dec[3];
        w_new_idx     = w_dec[2:0];
        w_p_next      = (r_phase_idx == phase_idx_t'(NUM_PHASES - 1)) ? '0 : r_phase_idx + 1'b1;
        w_p_prev      = (r_phase_idx == '0) ? phase_idx_t'(NUM_PHASES - 1) : r_phase_idx - 1'b1;
        w_change      = (w_synced != r_prev);
        w_fwd         = (w_new_idx == w_p_next);
        w_bwd         = (w_new_idx == w_p_prev);
        w_legal_chg   = w_change && w_new_valid;
        w_illegal_chg = w_change && !w_new_valid;
        w_is_step     = w_legal_chg && r_phase_valid && (w_fwd || w_bwd);
        w_is_skip     = w_legal_chg && r_phase_valid && !(w_fwd || w_bwd);
        w_err_pat_set = w_illegal_chg && r_phase_valid;
        // A step landing on the last allowed cycle rescues the lock.
        w_timeout     = (r_state == c_st_locked) && (r_gap == c_timeout_last) && !w_is_step;
    end

    // Lock state and same-direction step count.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        if (w_is_skip || w_illegal_chg || w_timeout) begin
            w_state_next = c_st_unlocked;
            w_good_next  = '0;
        end else if (w_legal_chg) begin
            case (r_state)
                c_st_unlocked: begin
                    w_state_next = c_st_acquire;
                    w_good_next  = '0;
                end
                c_st_acquire: begin
                    if (w_is_step) begin
                        w_good_next = (w_fwd == r_dir) ? r_good + 1'b1 : GOOD_W'(1);
                        if (w_good_next == c_lock_steps) begin
                            w_state_next = c_st_locked;
                        end
                    end
                end
                c_st_locked: begin
                    if (w_is_step && (w_fwd != r_dir)) begin
                        w_state_next = c_st_acquire;
                        w_good_next  = GOOD_W'(1);
                    end
                end
                default: begin
                    w_state_next = c_st_unlocked;
                    w_good_next  = '0;
                end
            endcase
        end
    end

    // Previous pattern, decoded phase, step pulse and direction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev        <= '0;
            r_phase_idx   <= '0;
            r_phase_valid <= 1'b0;
            r_step        <= 1'b0;
            r_dir         <= 1'b0;
        end else begin
            r_prev <= w_synced;
            r_step <= w_is_step;
            if (w_legal_chg) begin
                r_phase_idx   <= w_new_idx;
                r_phase_valid <= 1'b1;
            end else if (w_illegal_chg) begin
                r_phase_valid <= 1'b0;
            end
            if (w_is_step) begin
                r_dir <= w_fwd;
            end
        end
    end

    // FSM registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_unlocked;
            r_good  <= '0;
        end else begin
            r_state <= w_state_next;
            r_good  <= w_good_next;
        end
    end

    // Saturating gap counter; interval captures the step-to-step distance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gap      <= '0;
            r_interval <= '0;
        end else if (w_is_step) begin
            r_gap      <= '0;
            r_interval <= (r_gap == '1) ? r_gap : r_gap + 1'b1;
        end else if (r_gap != '1) begin
            r_gap <= r_gap + 1'b1;
        end
    end

    // Sticky error flags; a set in the clearing cycle keeps the flag high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_pattern <= 1'b0;
            r_err_skip    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_err_pat_set)      r_err_pattern <= 1'b1;
            else if (bus.clear_err) r_err_pattern <= 1'b0;
            if (w_is_skip)          r_err_skip    <= 1'b1;
            else if (bus.clear_err) r_err_skip    <= 1'b0;
            if (w_timeout)          r_err_timeout <= 1'b1;
            else if (bus.clear_err) r_err_timeout <= 1'b0;
        end
    end

    assign bus.phase_idx   = r_phase_idx;
    assign bus.phase_valid = r_phase_valid;
    assign bus.step        = r_step;
    assign bus.dir         = r_dir;
    assign bus.locked      = (r_state == c_st_locked);
    assign bus.interval    = r_interval;
    assign bus.err_pattern = r_err_pattern;
    assign bus.err_skip    = r_err_skip;
    assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire
